// File: rtl/menu_controller.sv
// Title-screen front end: debounces the four push-buttons, runs the screen FSM, blinks the menu cursor.
// Latency: raw button to press pulse is 2 + DB_CYCLES + 1 cycles; press pulse to state/menu_sel is 1 cycle.
// Backpressure: none; a free-running block whose outputs are registered levels or one-cycle pulses.
// Ports: clk/rst_n (async active-low); btn_up/btn_down/btn_enter/btn_back raw active-high buttons;
//        game_over synchronous level from the game core; state, menu_sel, show_menu, cursor_on and
//        start_pulse are all registered and feed menu_display and the game core.
module menu_controller #(
  parameter int DB_CYCLES    = 250000,
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_enter,
  input  logic       btn_back,
  input  logic       game_over,
  output logic [1:0] state,
  output logic       menu_sel,
  output logic       show_menu,
  output logic       cursor_on,
  output logic       start_pulse
);

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_CYCLES - 1);

  // Bit positions inside the packed button vectors.
  localparam int B_UP    = 0;
  localparam int B_DOWN  = 1;
  localparam int B_ENTER = 2;
  localparam int B_BACK  = 3;

  typedef enum logic [1:0] {
    S_MENU    = 2'b00,
    S_PLAY    = 2'b01,
    S_SETTING = 2'b10,
    S_OVER    = 2'b11
  } state_t;

  logic [3:0]      btn_raw;
  logic [3:0]      sync1, sync2;
  logic [3:0]      db_lvl, db_prev;
  logic [3:0]      press;
  logic [DB_W-1:0] db_cnt [4];

  assign btn_raw = {btn_back, btn_enter, btn_down, btn_up};

  // Synchronizer, per-button debounce counter and registered rising-edge press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      db_lvl  <= '0;
      db_prev <= '0;
      press   <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      db_prev <= db_lvl;
      press   <= db_lvl & ~db_prev;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          db_cnt[i] <= '0;
          db_lvl[i] <= ~db_lvl[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  state_t          state_q, state_d;
  logic            sel_q, sel_d;
  logic            start_q, start_d;
  logic            show_q;
  logic            cursor_q, cursor_d;
  logic [BL_W-1:0] blink_q, blink_d;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    start_d  = 1'b0;
    blink_d  = blink_q;
    cursor_d = cursor_q;

    case (state_q)
      S_MENU: begin
        // Enter wins over up/down; up and down together cancel out.
        if (press[B_ENTER]) begin
          if (!sel_q) begin
            state_d = S_PLAY;
            start_d = 1'b1;
          end else begin
            state_d = S_SETTING;
          end
        end else if (press[B_UP] && !press[B_DOWN]) begin
          sel_d = 1'b0;
        end else if (press[B_DOWN] && !press[B_UP]) begin
          sel_d = 1'b1;
        end
      end
      S_SETTING: begin
        if (press[B_ENTER] || press[B_BACK]) begin
          state_d = S_MENU;
          sel_d   = 1'b1;
        end
      end
      S_PLAY: begin
        if (game_over) state_d = S_OVER;
      end
      S_OVER: begin
        if (press[B_ENTER]) begin
          state_d = S_MENU;
          sel_d   = 1'b0;
        end
      end
    endcase

    // Cursor blink keys off the next state so it lines up with the state register.
    if (state_d != S_MENU) begin
      blink_d  = '0;
      cursor_d = 1'b0;
    end else if ((state_q != S_MENU) || (sel_d != sel_q)) begin
      // Fresh highlight: restart the phase with the cursor visible.
      blink_d  = '0;
      cursor_d = 1'b1;
    end else if (blink_q == BL_MAX) begin
      blink_d  = '0;
      cursor_d = ~cursor_q;
    end else begin
      blink_d = blink_q + BL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_MENU;
      sel_q    <= 1'b0;
      start_q  <= 1'b0;
      show_q   <= 1'b1;
      cursor_q <= 1'b1;
      blink_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      start_q  <= start_d;
      show_q   <= (state_d == S_MENU);
      cursor_q <= cursor_d;
      blink_q  <= blink_d;
    end
  end

  assign state       = state_q;
  assign menu_sel    = sel_q;
  assign show_menu   = show_q;
  assign cursor_on   = cursor_q;
  assign start_pulse = start_q;

endmodule

// File: tb/tb_menu_controller.sv
// Bench for menu_controller: directed scenarios plus randomized button/game_over activity,
// compared every cycle against a behavioural model of the screen rules.
module tb_menu_controller;

  localparam int DB = 4;
  localparam int BL = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'b0;   // 0 up, 1 down, 2 enter, 3 back
  logic       game_over = 1'b0;
  logic [1:0] state;
  logic       menu_sel, show_menu, cursor_on, start_pulse;

  int checks = 0;
  int errors = 0;

  menu_controller #(.DB_CYCLES(DB), .BLINK_CYCLES(BL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up     (btn[0]),
    .btn_down   (btn[1]),
    .btn_enter  (btn[2]),
    .btn_back   (btn[3]),
    .game_over  (game_over),
    .state      (state),
    .menu_sel   (menu_sel),
    .show_menu  (show_menu),
    .cursor_on  (cursor_on),
    .start_pulse(start_pulse)
  );

  always #5 clk = ~clk;

  // Reference model state.
  int        m_st;          // 0 MENU, 1 PLAY, 2 SETTING, 3 OVER
  bit        m_sel, m_start, m_cur;
  int        m_run;         // MENU cycles since the cursor was last restarted
  bit [3:0]  m_db;          // debounced levels
  bit [3:0]  m_rose;        // debounced rising edge seen on the last edge
  bit [3:0]  m_pr;          // press pulse visible to the screen logic
  bit [31:0] m_hist [4];    // raw samples, bit0 = most recent edge

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_sel = 1'b0; m_start = 1'b0; m_cur = 1'b1; m_run = 0;
    m_db = '0; m_rose = '0; m_pr = '0;
    for (int b = 0; b < 4; b++) m_hist[b] = '0;
  endtask

  task automatic model_step();
    int       ns;
    bit       nsel, nstart, differ;
    bit [3:0] nxt_pr;
    ns = m_st; nsel = m_sel; nstart = 1'b0;
    case (m_st)
      0: begin
        if (m_pr[2]) begin
          if (!m_sel) begin ns = 1; nstart = 1'b1; end
          else ns = 2;
        end else if (m_pr[0] != m_pr[1]) begin
          nsel = m_pr[1];   // exactly one of up/down pressed
        end
      end
      1: if (game_over) ns = 3;
      2: if (m_pr[2] || m_pr[3]) ns = 0;
      default: if (m_pr[2]) begin ns = 0; nsel = 1'b0; end
    endcase
    if (ns != 0) begin
      m_run = 0; m_cur = 1'b0;
    end else if (m_st != 0 || nsel != m_sel) begin
      m_run = 0; m_cur = 1'b1;
    end else begin
      m_run++;
      m_cur = ((m_run / BL) % 2) == 0;
    end
    m_st = ns; m_sel = nsel; m_start = nstart;

    // A debounced level flips once the synchronized input (raw delayed two
    // edges) has disagreed with it for DB consecutive edges.
    nxt_pr = m_rose;
    m_rose = '0;
    for (int b = 0; b < 4; b++) begin
      differ = 1'b1;
      for (int j = 1; j <= DB; j++) if (m_hist[b][j] == m_db[b]) differ = 1'b0;
      if (differ) begin
        m_db[b]   = ~m_db[b];
        m_rose[b] = m_db[b];
      end
      m_hist[b] = {m_hist[b][30:0], btn[b]};
    end
    m_pr = nxt_pr;
  endtask

  task automatic compare_all();
    chk("state", int'(state), m_st);
    chk("menu_sel", int'(menu_sel), int'(m_sel));
    chk("show_menu", int'(show_menu), int'(m_st == 0));
    chk("cursor_on", int'(cursor_on), int'(m_cur));
    chk("start_pulse", int'(start_pulse), int'(m_start));
  endtask

  // One clock: model follows the DUT edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic rise(input int b);
    btn[b] = 1'b1;
    repeat (8) cyc();
  endtask

  task automatic fall(input int b);
    btn[b] = 1'b0;
    repeat (8) cyc();
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // Reset with buttons toggling.
    for (int i = 0; i < 10; i++) begin
      btn = 4'($urandom);
      game_over = 1'($urandom_range(0, 1));
      cyc();
    end
    chk("rst_state", int'(state), 0);
    chk("rst_sel", int'(menu_sel), 0);
    chk("rst_show", int'(show_menu), 1);
    chk("rst_cursor", int'(cursor_on), 1);
    chk("rst_start", int'(start_pulse), 0);
    btn = 4'b0; game_over = 1'b0;
    rst_n = 1'b1;
    repeat (20) cyc();
    chk("idle_state", int'(state), 0);
    chk("idle_sel", int'(menu_sel), 0);

    // Debounce: a 3-cycle glitch is filtered, a held press lands 8 cycles after the rise.
    btn[1] = 1'b1;
    repeat (3) cyc();
    btn[1] = 1'b0;
    repeat (12) cyc();
    chk("glitch_sel", int'(menu_sel), 0);
    btn[1] = 1'b1;
    repeat (7) cyc();
    chk("db_sel_7", int'(menu_sel), 0);
    cyc();
    chk("db_sel_8", int'(menu_sel), 1);
    fall(1);
    rise(1);
    chk("sat_sel", int'(menu_sel), 1);
    fall(1);

    // Start path.
    rise(0);
    chk("up_sel", int'(menu_sel), 0);
    fall(0);
    rise(2);
    chk("start_state", int'(state), 1);
    chk("start_pulse_hi", int'(start_pulse), 1);
    chk("start_show", int'(show_menu), 0);
    chk("start_cursor", int'(cursor_on), 0);
    cyc();
    chk("start_pulse_lo", int'(start_pulse), 0);
    fall(2);
    rise(1); fall(1);
    rise(0); fall(0);
    chk("play_state", int'(state), 1);
    chk("play_sel", int'(menu_sel), 0);

    // Game-over loop.
    game_over = 1'b1;
    cyc();
    chk("over_state", int'(state), 3);
    game_over = 1'b0;
    rise(2);
    chk("over_exit_state", int'(state), 0);
    chk("over_exit_sel", int'(menu_sel), 0);
    chk("over_exit_cursor", int'(cursor_on), 1);
    fall(2);

    // Settings round trip.
    rise(1); fall(1);
    rise(2);
    chk("set_state", int'(state), 2);
    fall(2);
    rise(3);
    chk("set_exit_state", int'(state), 0);
    chk("set_exit_sel", int'(menu_sel), 1);
    chk("set_exit_cursor", int'(cursor_on), 1);

    // Blink period, measured from the MENU entry edge.
    btn[3] = 1'b0;
    repeat (7) cyc();
    chk("blink_hold", int'(cursor_on), 1);
    cyc();
    chk("blink_off", int'(cursor_on), 0);
    repeat (8) cyc();
    chk("blink_on", int'(cursor_on), 1);

    // Up and down together: no selection change, blink phase undisturbed.
    btn[0] = 1'b1; btn[1] = 1'b1;
    repeat (8) cyc();
    chk("simul_sel", int'(menu_sel), 1);
    btn = 4'b0;
    repeat (8) cyc();
    chk("simul_blink", int'(cursor_on), 1);
    rise(0);
    chk("restart_sel", int'(menu_sel), 0);
    chk("restart_cursor", int'(cursor_on), 1);
    btn[0] = 1'b0;
    repeat (7) cyc();
    chk("restart_hold", int'(cursor_on), 1);
    cyc();
    chk("restart_off", int'(cursor_on), 0);

    // Asynchronous reset mid-game with enter held through it.
    rise(2);
    chk("pre_rst_state", int'(state), 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_show", int'(show_menu), 1);
    chk("arst_cursor", int'(cursor_on), 1);
    chk("arst_start", int'(start_pulse), 0);
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (10) cyc();
    chk("held_enter_state", int'(state), 1);
    btn = 4'b0;
    repeat (10) cyc();

    // Randomized activity, checked every cycle against the model.
    for (int s = 0; s < 150; s++) begin
      btn = 4'b0;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) btn[b] = 1'b1;
      game_over = ($urandom_range(0, 7) == 0);
      repeat ($urandom_range(1, 12)) cyc();
    end
    btn = 4'b0; game_over = 1'b0;
    repeat (10) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
